// File: rtl/qspi_cmd_regs.sv
// qspi_cmd_regs: command decoder and register file behind the QSPI slave.
// The first byte of each frame is a command: bit 7 = RW (1 read), bits 6:ADDR_W
// reserved (must be 0), bits ADDR_W-1:0 = start address. Writes and reads then
// auto-increment the address pointer. The top address is read-only and returns ID_VALUE.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   frame_active      chip-select asserted, already synchronised to clk
//   rx_data, rx_valid received byte and its one-cycle strobe
//   tx_data           registered byte for the slave transmitter
//   leds              reg[0][3:0]
//   cmd_error         invalid command seen; cleared at the next frame start
//   frame_count       completed frames, wraps at 255
module qspi_cmd_regs #(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_active,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic [3:0] leds,
  output logic       cmd_error,
  output logic [7:0] frame_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        tx_q, tx_d;
  logic              err_q, err_d;
  logic [7:0]        fc_q, fc_d;
  logic              fa_q;
  logic [7:0]        regs_q [DEPTH];

  logic              we_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [7:0]        rd_data_c;
  logic [6:0]        rsvd_c;

  // Address of the byte to load onto tx: the command's address, or the next pointer.
  always_comb begin
    rd_addr_c = (state_q == S_CMD) ? rx_data[ADDR_W-1:0] : ptr_q + ADDR_W'(1);
    rd_data_c = (rd_addr_c == TOP_ADDR) ? ID_VALUE : regs_q[rd_addr_c];
    rsvd_c    = rx_data[6:0] >> ADDR_W;
  end

  // Next-state and datapath control; frame end takes priority over any byte.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    err_d   = err_q;
    fc_d    = fc_q;
    we_c    = 1'b0;

    if (state_q == S_IDLE) begin
      if (frame_active && !fa_q) begin
        state_d = S_CMD;
        err_d   = 1'b0;
      end
    end else if (!frame_active) begin
      state_d = S_IDLE;
      fc_d    = fc_q + 8'd1;
    end else if (rx_valid) begin
      unique case (state_q)
        S_CMD: begin
          if (rsvd_c != 7'd0) begin
            state_d = S_DISCARD;
            err_d   = 1'b1;
          end else begin
            ptr_d = rx_data[ADDR_W-1:0];
            if (rx_data[7]) begin
              state_d = S_READ;
              tx_d    = rd_data_c;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_c  = (ptr_q != TOP_ADDR);
          ptr_d = ptr_q + ADDR_W'(1);
        end
        S_READ: begin
          ptr_d = ptr_q + ADDR_W'(1);
          tx_d  = rd_data_c;
        end
        default: ;
      endcase
    end
  end

  // State and output registers. fa_q resets high so a frame in progress
  // at reset release is not mistaken for a new frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
      fc_q    <= '0;
      fa_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
      fa_q    <= frame_active;
    end
  end

  // Register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_c) begin
      regs_q[ptr_q] <= rx_data;
    end
  end

  assign tx_data     = tx_q;
  assign leds        = regs_q[0][3:0];
  assign cmd_error   = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_qspi_cmd_regs.sv
// Directed bench for qspi_cmd_regs: inputs change and outputs are sampled on negedge.
module tb_qspi_cmd_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic [3:0] leds;
  logic       cmd_error;
  logic [7:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  qspi_cmd_regs #(.ADDR_W(4), .ID_VALUE(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_active(frame_active),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .leds        (leds),
    .cmd_error   (cmd_error),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    frame_active = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_leds", {4'h0, leds}, 8'h00);
    chk("rst_err", {7'h0, cmd_error}, 8'h00);
    chk("rst_fc", frame_count, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Write reg0=0F, reg1=33
    start_frame();
    send(8'h00);
    send(8'h0F);
    chk("w1_leds", {4'h0, leds}, 8'h0F);
    send(8'h33);
    end_frame();
    chk("w1_fc", frame_count, 8'd1);
    start_frame();
    send(8'h80);
    chk("r1_reg0", tx_data, 8'h0F);
    send(8'hFF);
    chk("r1_reg1", tx_data, 8'h33);
    end_frame();
    chk("r1_fc", frame_count, 8'd2);

    // Write across read-only top address with wrap
    start_frame();
    send(8'h0E);
    send(8'h11);
    send(8'h22);
    send(8'h44);
    chk("w2_leds", {4'h0, leds}, 8'h04);
    end_frame();
    start_frame();
    send(8'h8E);
    chk("r2_reg14", tx_data, 8'h11);
    send(8'h00);
    chk("r2_id", tx_data, 8'hA5);
    send(8'h00);
    chk("r2_reg0_wrap", tx_data, 8'h44);
    end_frame();
    chk("r2_fc", frame_count, 8'd4);

    // Read sequence from reg1
    start_frame();
    send(8'h01);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    end_frame();
    start_frame();
    send(8'h81);
    chk("r3_reg1", tx_data, 8'h10);
    send(8'hAA);
    chk("r3_reg2", tx_data, 8'h20);
    send(8'hAA);
    chk("r3_reg3", tx_data, 8'h30);
    send(8'hAA);
    chk("r3_reg4", tx_data, 8'h00);
    end_frame();
    chk("r3_hold", tx_data, 8'h00);
    chk("r3_fc", frame_count, 8'd6);

    // Invalid command then discarded byte
    start_frame();
    send(8'h40);
    chk("bad_err", {7'h0, cmd_error}, 8'h01);
    send(8'h55);
    end_frame();
    chk("bad_err_hold", {7'h0, cmd_error}, 8'h01);
    chk("bad_fc", frame_count, 8'd7);
    start_frame();
    chk("bad_err_clr", {7'h0, cmd_error}, 8'h00);
    send(8'h80);
    chk("bad_reg0", tx_data, 8'h44);
    chk("bad_leds", {4'h0, leds}, 8'h04);
    end_frame();
    chk("idle_hold_tx", tx_data, 8'h44);

    // One-cycle frame still counts
    @(negedge clk);
    frame_active = 1'b1;
    @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
    chk("short_fc", frame_count, 8'd9);

    // Byte coinciding with frame end is dropped
    start_frame();
    send(8'h05);
    send(8'h77);
    @(negedge clk);
    rx_data      = 8'h99;
    rx_valid     = 1'b1;
    frame_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("coll_fc", frame_count, 8'd10);
    start_frame();
    send(8'h85);
    chk("coll_reg5", tx_data, 8'h77);
    send(8'h00);
    chk("coll_reg6", tx_data, 8'h00);
    end_frame();

    // Reset mid-frame, frame in progress is not rejoined
    start_frame();
    send(8'h00);
    send(8'h0A);
    chk("mid_leds", {4'h0, leds}, 8'h0A);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_leds", {4'h0, leds}, 8'h00);
    chk("mrst_fc", frame_count, 8'h00);
    chk("mrst_tx", tx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    send(8'h00);
    send(8'h0C);
    chk("post_leds", {4'h0, leds}, 8'h00);
    end_frame();
    chk("post_fc", frame_count, 8'h00);
    start_frame();
    send(8'h80);
    chk("post_reg0", tx_data, 8'h00);
    send(8'h00);
    chk("post_reg1", tx_data, 8'h00);
    end_frame();
    chk("post_fc2", frame_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
